// File: rtl/bin_to_bcd_disp.sv
// ============================================================================
// Module   : bin_to_bcd_disp
// Purpose  : Iterative shift-and-add-3 binary-to-packed-BCD converter that
//            feeds the four-digit seven-segment driver; load/ready/valid
//            handshake. Optional macro BCD_SAT_EN saturates >9999 to 9999.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin_to_bcd_disp #(
  parameter int BIN_W = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BIN_W-1:0] bin_in,
  input  logic             load,
  output logic             ready,
  output logic [15:0]      bcd_out,
  output logic             valid,
  output logic             ovf
);

  localparam logic [3:0] LAST_BIT = 4'(BIN_W - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_next;
  logic [BIN_W-1:0] shreg, shreg_shifted;
  logic [15:0]      scratch, scratch_adj, scratch_shifted, result;
  logic [3:0]       bit_cnt;
  logic             accept, last_cycle, result_ovf;

  assign ready      = (state == IDLE);
  assign accept     = (state == IDLE) && load;
  assign last_cycle = (state == SHIFT) && (bit_cnt == LAST_BIT);

  // Digit correction happens before the shift so a digit >=5 carries into
  // its neighbour as the shift doubles it.
  for (genvar i = 0; i < 4; i++) begin : g_digit
    assign scratch_adj[4*i +: 4] = (scratch[4*i +: 4] >= 4'd5) ?
                                   scratch[4*i +: 4] + 4'd3 :
                                   scratch[4*i +: 4];
  end

  assign scratch_shifted = {scratch_adj[14:0], shreg[BIN_W-1]};
  assign shreg_shifted   = {shreg[BIN_W-2:0], 1'b0};

`ifdef BCD_SAT_EN
  logic sat_flag;
  logic ovf_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_flag <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      if (accept)
        sat_flag <= (bin_in > BIN_W'(9999));
      if (last_cycle)
        ovf_r <= sat_flag;
    end
  end

  assign result     = sat_flag ? 16'h9999 : scratch_shifted;
  assign result_ovf = sat_flag;
  assign ovf        = ovf_r;
`else
  assign result     = scratch_shifted;
  assign result_ovf = 1'b0;
  assign ovf        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load) state_next = SHIFT;
      SHIFT:   if (bit_cnt == LAST_BIT) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      scratch <= '0;
      bit_cnt <= '0;
      bcd_out <= '0;
      valid   <= 1'b0;
    end else begin
      valid <= last_cycle;
      if (accept) begin
        shreg   <= bin_in;
        scratch <= '0;
        bit_cnt <= '0;
      end else if (state == SHIFT) begin
        shreg   <= shreg_shifted;
        scratch <= scratch_shifted;
        bit_cnt <= bit_cnt + 4'd1;
      end
      if (last_cycle)
        bcd_out <= result;
    end
  end

  // result_ovf is only consumed by the saturating build.
  logic unused_ok;
  assign unused_ok = result_ovf;

endmodule

`default_nettype wire

// File: tb/tb_bin_to_bcd_disp.sv
// ============================================================================
// Module   : tb_bin_to_bcd_disp
// Purpose  : Directed self-checking bench for bin_to_bcd_disp.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bin_to_bcd_disp;

  logic        clk;
  logic        rst_n;
  logic [13:0] bin_in;
  logic        load;
  logic        ready;
  logic [15:0] bcd_out;
  logic        valid;
  logic        ovf;

  int total = 0;
  int bad   = 0;

  bin_to_bcd_disp #(.BIN_W(14)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bin_in  (bin_in),
    .load    (load),
    .ready   (ready),
    .bcd_out (bcd_out),
    .valid   (valid),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus only: issue one load, observe 20 edges, report what was seen.
  task automatic run_conv(input logic [13:0] v, input int busy_at,
                          input logic [13:0] busy_val,
                          output int lat, output int valids,
                          output logic [15:0] bcd, output logic ov,
                          output logic ready_bad, output logic hold_bad);
    logic [15:0] prev;
    lat = 0; valids = 0; bcd = 16'hxxxx; ov = 1'bx;
    ready_bad = 1'b0; hold_bad = 1'b0;
    @(negedge clk);
    prev   = bcd_out;
    bin_in = v;
    load   = 1'b1;
    @(posedge clk); #1;
    load   = 1'b0;
    bin_in = v ^ 14'h2AAA;
    if (ready !== 1'b0) ready_bad = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == busy_at) begin
        load = 1'b1; bin_in = busy_val;
      end else if (k == busy_at + 1) begin
        load = 1'b0;
      end
      if (valid === 1'b1) begin
        valids++;
        if (lat == 0) begin
          lat = k; bcd = bcd_out; ov = ovf;
          if (ready !== 1'b1) ready_bad = 1'b1;
        end
      end else if (lat == 0 && bcd_out !== prev) begin
        hold_bad = 1'b1;
      end
      if (k < 14 && ready !== 1'b0) ready_bad = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; load = 1'b0; bin_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", ready); end
    total++; if (bcd_out !== 16'h0000) begin bad++; $display("FAIL reset_bcd got=%h exp=0000", bcd_out); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
  endtask

  task automatic test_basic;
    int lat, valids; logic [15:0] bcd; logic ov, rb, hb;
    run_conv(14'd1234, -10, 14'd0, lat, valids, bcd, ov, rb, hb);
    total++; if (lat !== 14) begin bad++; $display("FAIL basic_latency got=%0d exp=14", lat); end
    total++; if (valids !== 1) begin bad++; $display("FAIL basic_valid_count got=%0d exp=1", valids); end
    total++; if (bcd !== 16'h1234) begin bad++; $display("FAIL basic_bcd got=%h exp=1234", bcd); end
    total++; if (ov !== 1'b0) begin bad++; $display("FAIL basic_ovf got=%b exp=0", ov); end
    total++; if (rb !== 1'b0) begin bad++; $display("FAIL basic_ready_window got=%b exp=0", rb); end
    total++; if (hb !== 1'b0) begin bad++; $display("FAIL basic_bcd_hold got=%b exp=0", hb); end
  endtask

  task automatic test_corners;
    logic [13:0] vin [4]  = '{14'd0, 14'd9999, 14'd10, 14'd4095};
    logic [15:0] vexp [4] = '{16'h0000, 16'h9999, 16'h0010, 16'h4095};
    int lat, valids; logic [15:0] bcd; logic ov, rb, hb;
    for (int i = 0; i < 4; i++) begin
      run_conv(vin[i], -10, 14'd0, lat, valids, bcd, ov, rb, hb);
      total++; if (bcd !== vexp[i]) begin bad++; $display("FAIL corner_bcd in=%0d got=%h exp=%h", vin[i], bcd, vexp[i]); end
      total++; if (lat !== 14 || valids !== 1) begin bad++; $display("FAIL corner_timing in=%0d lat=%0d valids=%0d exp=14/1", vin[i], lat, valids); end
      total++; if (ov !== 1'b0) begin bad++; $display("FAIL corner_ovf in=%0d got=%b exp=0", vin[i], ov); end
      total++; if (hb !== 1'b0) begin bad++; $display("FAIL corner_hold in=%0d got=%b exp=0", vin[i], hb); end
    end
  endtask

  task automatic test_load_while_busy;
    int lat, valids; logic [15:0] bcd; logic ov, rb, hb;
    run_conv(14'd42, 4, 14'd777, lat, valids, bcd, ov, rb, hb);
    total++; if (bcd !== 16'h0042) begin bad++; $display("FAIL busy_bcd got=%h exp=0042", bcd); end
    total++; if (valids !== 1) begin bad++; $display("FAIL busy_valid_count got=%0d exp=1", valids); end
    total++; if (lat !== 14) begin bad++; $display("FAIL busy_latency got=%0d exp=14", lat); end
  endtask

  task automatic test_overflow;
    int lat, valids; logic [15:0] bcd; logic ov, rb, hb;
`ifdef BCD_SAT_EN
    logic [15:0] exp_bcd = 16'h9999;
    logic        exp_ovf = 1'b1;
`else
    logic [15:0] exp_bcd = 16'h6383;
    logic        exp_ovf = 1'b0;
`endif
    run_conv(14'd16383, -10, 14'd0, lat, valids, bcd, ov, rb, hb);
    total++; if (bcd !== exp_bcd) begin bad++; $display("FAIL ovf_bcd got=%h exp=%h", bcd, exp_bcd); end
    total++; if (ov !== exp_ovf) begin bad++; $display("FAIL ovf_flag got=%b exp=%b", ov, exp_ovf); end
    total++; if (lat !== 14) begin bad++; $display("FAIL ovf_latency got=%0d exp=14", lat); end
    run_conv(14'd10000, -10, 14'd0, lat, valids, bcd, ov, rb, hb);
`ifdef BCD_SAT_EN
    exp_bcd = 16'h9999;
`else
    exp_bcd = 16'h0000;
`endif
    total++; if (bcd !== exp_bcd) begin bad++; $display("FAIL ovf10000_bcd got=%h exp=%h", bcd, exp_bcd); end
    total++; if (ov !== exp_ovf) begin bad++; $display("FAIL ovf10000_flag got=%b exp=%b", ov, exp_ovf); end
    // In-range value following an overflow must clear the flag.
    run_conv(14'd321, -10, 14'd0, lat, valids, bcd, ov, rb, hb);
    total++; if (bcd !== 16'h0321 || ov !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%h/%b exp=0321/0", bcd, ov); end
  endtask

  task automatic test_back_to_back;
    int v1 = 0, v2 = 0;
    logic [15:0] b1 = '0, b2 = '0;
    @(negedge clk);
    bin_in = 14'd2468; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0; bin_in = 14'd0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 15) load = 1'b0;
      if (valid === 1'b1) begin
        if (v1 == 0) begin v1 = k; b1 = bcd_out; end
        else if (v2 == 0) begin v2 = k; b2 = bcd_out; end
      end
      if (k == 14) begin load = 1'b1; bin_in = 14'd8135; end
    end
    total++; if (v1 !== 14 || b1 !== 16'h2468) begin bad++; $display("FAIL b2b_first got=%0d/%h exp=14/2468", v1, b1); end
    total++; if (v2 !== 29 || b2 !== 16'h8135) begin bad++; $display("FAIL b2b_second got=%0d/%h exp=29/8135", v2, b2); end
  endtask

  task automatic test_reset_mid;
    int lat, valids; logic [15:0] bcd; logic ov, rb, hb;
    int seen = 0;
    @(negedge clk);
    bin_in = 14'd5678; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      if (valid === 1'b1) seen++;
    end
    rst_n = 1'b0;
    #1;
    total++; if (bcd_out !== 16'h0000 || ready !== 1'b1 || valid !== 1'b0)
      begin bad++; $display("FAIL rstmid_outputs got bcd=%h ready=%b valid=%b exp=0000/1/0", bcd_out, ready, valid); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (valid === 1'b1) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL rstmid_no_valid got=%0d exp=0", seen); end
    run_conv(14'd5678, -10, 14'd0, lat, valids, bcd, ov, rb, hb);
    total++; if (bcd !== 16'h5678 || lat !== 14) begin bad++; $display("FAIL rstmid_reconvert got=%h lat=%0d exp=5678/14", bcd, lat); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_load_while_busy();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
